// File: rtl/instruction_decode_reg.sv
// rtl/instruction_decode_reg.sv - IF/ID pipeline register with field decode
// Holds the fetched instruction and PC+4; all decode outputs are sliced from registered state.
module instruction_decode_reg #(
   parameter int NB_INSTR = 32,
   parameter int NB_DATA  = 32,
   parameter int NB_IMM   = 16,
   parameter int NB_REG   = 5
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NB_INSTR-1:0] i_instruction,
   input  logic [NB_DATA-1:0]  i_pc4,
   input  logic                i_valid,
   input  logic                i_stall,
   input  logic                i_flush,
   output logic [5:0]          o_opcode,
   output logic [NB_REG-1:0]   o_rs,
   output logic [NB_REG-1:0]   o_rt,
   output logic [NB_REG-1:0]   o_rd,
   output logic [4:0]          o_shamt,
   output logic [5:0]          o_funct,
   output logic [NB_IMM-1:0]   o_immediate,
   output logic                o_immediate_flag,
   output logic [25:0]         o_jump_addr,
   output logic [NB_DATA-1:0]  o_pc4,
   output logic                o_is_rtype,
   output logic                o_valid
);

   logic [NB_INSTR-1:0] instr_q, instr_d;
   logic [NB_DATA-1:0]  pc4_q, pc4_d;
   logic                valid_q, valid_d;

   // Flush beats stall; a bubble is stored as all-zero so it decodes as NOP.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (i_flush) begin
         instr_d = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (!i_stall) begin
         instr_d = i_valid ? i_instruction : '0;
         pc4_d   = i_pc4;
         valid_d = i_valid;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign o_opcode    = instr_q[31:26];
   assign o_rs        = instr_q[21 +: NB_REG];
   assign o_rt        = instr_q[16 +: NB_REG];
   assign o_rd        = instr_q[11 +: NB_REG];
   assign o_shamt     = instr_q[10:6];
   assign o_funct     = instr_q[5:0];
   assign o_immediate = instr_q[NB_IMM-1:0];
   assign o_jump_addr = instr_q[25:0];
   assign o_pc4       = pc4_q;
   assign o_valid     = valid_q;
   assign o_is_rtype  = (instr_q[31:26] == 6'h00);

   // ANDI/ORI/XORI/LUI (0x0C..0x0F) share opcode[5:2] == 4'b0011 and zero-extend.
   assign o_immediate_flag = (instr_q[31:28] != 4'b0011);

endmodule

// File: tb/tb_instruction_decode_reg.sv
// tb/tb_instruction_decode_reg.sv - randomized self-checking bench for instruction_decode_reg
// Reference model tracks the stage contents and decodes fields arithmetically.
module tb_instruction_decode_reg;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_instruction;
   logic [31:0] i_pc4;
   logic        i_valid;
   logic        i_stall;
   logic        i_flush;
   logic [5:0]  o_opcode;
   logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
   logic [5:0]  o_funct;
   logic [15:0] o_immediate;
   logic        o_immediate_flag;
   logic [25:0] o_jump_addr;
   logic [31:0] o_pc4;
   logic        o_is_rtype;
   logic        o_valid;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_instr, m_pc4;
   logic        m_valid;
   logic [31:0] held;

   instruction_decode_reg dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_instruction(i_instruction), .i_pc4(i_pc4),
      .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
      .o_opcode(o_opcode), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
      .o_shamt(o_shamt), .o_funct(o_funct), .o_immediate(o_immediate),
      .o_immediate_flag(o_immediate_flag), .o_jump_addr(o_jump_addr),
      .o_pc4(o_pc4), .o_is_rtype(o_is_rtype), .o_valid(o_valid)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int op;
      op = int'(m_instr / 32'd67108864);
      check({tag, ".opcode"}, 32'(o_opcode),   32'(op));
      check({tag, ".rs"},     32'(o_rs),       (m_instr / 32'd2097152) % 32);
      check({tag, ".rt"},     32'(o_rt),       (m_instr / 32'd65536) % 32);
      check({tag, ".rd"},     32'(o_rd),       (m_instr / 32'd2048) % 32);
      check({tag, ".shamt"},  32'(o_shamt),    (m_instr / 32'd64) % 32);
      check({tag, ".funct"},  32'(o_funct),    m_instr % 64);
      check({tag, ".imm"},    32'(o_immediate), m_instr % 65536);
      check({tag, ".jaddr"},  32'(o_jump_addr), m_instr % 67108864);
      check({tag, ".flag"},   32'(o_immediate_flag), (op >= 12 && op <= 15) ? 32'd0 : 32'd1);
      check({tag, ".rtype"},  32'(o_is_rtype), (op == 0) ? 32'd1 : 32'd0);
      check({tag, ".pc4"},    o_pc4,           m_pc4);
      check({tag, ".valid"},  32'(o_valid),    32'(m_valid));
   endtask

   task automatic model_reset();
      m_instr = 0; m_pc4 = 0; m_valid = 0;
   endtask

   // One clock: update the model from the inputs seen at the edge, return at the falling edge.
   task automatic step();
      @(posedge i_clk);
      if (i_rst) model_reset();
      else if (i_flush) begin
         m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (!i_stall) begin
         m_instr = i_valid ? i_instruction : 32'h0;
         m_pc4   = i_pc4;
         m_valid = i_valid;
      end
      @(negedge i_clk);
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                        input logic st, input logic fl);
      i_instruction = ins; i_pc4 = pc; i_valid = v; i_stall = st; i_flush = fl;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[31:26] = 6'(12 + $urandom_range(0, 3));
      else if ($urandom_range(0, 3) == 0) r[31:26] = 6'h00;
      return r;
   endfunction

   initial begin
      i_rst = 1'b1;
      drive(32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0, 1'b0);
      model_reset();
      #12;
      check_all("reset");
      check("reset.flag_lit", 32'(o_immediate_flag), 32'd1);
      check("reset.rtype_lit", 32'(o_is_rtype), 32'd1);
      @(negedge i_clk);
      i_rst = 1'b0;

      drive(32'h2128FFFF, 32'h4, 1'b1, 1'b0, 1'b0);
      step();
      check("addi.opcode", 32'(o_opcode), 32'h08);
      check("addi.rs", 32'(o_rs), 32'd9);
      check("addi.rt", 32'(o_rt), 32'd8);
      check("addi.imm", 32'(o_immediate), 32'hFFFF);
      check("addi.flag", 32'(o_immediate_flag), 32'd1);
      check("addi.pc4", o_pc4, 32'h4);
      check("addi.valid", 32'(o_valid), 32'd1);
      check_all("addi");

      drive(32'h352800FF, 32'h8, 1'b1, 1'b0, 1'b0);
      step();
      check("ori.opcode", 32'(o_opcode), 32'h0D);
      check("ori.imm", 32'(o_immediate), 32'h00FF);
      check("ori.flag", 32'(o_immediate_flag), 32'd0);
      check("ori.rtype", 32'(o_is_rtype), 32'd0);
      check_all("ori");

      drive(32'h012A4020, 32'hC, 1'b1, 1'b0, 1'b0);
      step();
      check("add.rtype", 32'(o_is_rtype), 32'd1);
      check("add.rs", 32'(o_rs), 32'd9);
      check("add.rt", 32'(o_rt), 32'd10);
      check("add.rd", 32'(o_rd), 32'd8);
      check("add.funct", 32'(o_funct), 32'h20);
      check("add.flag", 32'(o_immediate_flag), 32'd1);
      check_all("add");

      // Three stall cycles with changing inputs, then a load.
      drive(32'h2128FFFF, 32'h10, 1'b1, 1'b0, 1'b0);
      step();
      for (int k = 0; k < 3; k++) begin
         drive($urandom, $urandom, 1'b1, 1'b1, 1'b0);
         step();
         check("stall.imm", 32'(o_immediate), 32'hFFFF);
         check("stall.pc4", o_pc4, 32'h10);
         check_all("stall");
      end
      drive(32'h352800FF, 32'h14, 1'b1, 1'b0, 1'b0);
      step();
      check("unstall.opcode", 32'(o_opcode), 32'h0D);
      check_all("unstall");

      drive(32'h2128FFFF, 32'h18, 1'b1, 1'b1, 1'b1);
      step();
      check("flush.valid", 32'(o_valid), 32'd0);
      check("flush.jaddr", 32'(o_jump_addr), 32'd0);
      check("flush.flag", 32'(o_immediate_flag), 32'd1);
      check_all("flush");

      drive(32'h3C0F1234, 32'h1C, 1'b0, 1'b0, 1'b0);
      step();
      check("bubble.opcode", 32'(o_opcode), 32'd0);
      check_all("bubble");

      // Reset asserted between edges must clear the stage immediately.
      drive(32'h012A4020, 32'h20, 1'b1, 1'b0, 1'b0);
      step();
      check("pre_arst.valid", 32'(o_valid), 32'd1);
      #2 i_rst = 1'b1;
      #1;
      model_reset();
      check("arst.valid", 32'(o_valid), 32'd0);
      check("arst.funct", 32'(o_funct), 32'd0);
      check_all("arst");
      step();
      check_all("arst_held");
      i_rst = 1'b0;
      drive(32'h352800FF, 32'h24, 1'b1, 1'b0, 1'b0);
      step();
      check_all("post_rst");

      for (int k = 0; k < 400; k++) begin
         drive(rand_instr(), $urandom, ($urandom_range(0, 9) < 8),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
         step();
         check_all("rand");
         if ($urandom_range(0, 3) == 0) begin
            held = m_instr;
            check("rand.hold_ref", 32'(o_opcode), held / 32'd67108864);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instruction_decode_reg.md
INSTRUCTION_DECODE_REG -- requirements
Module: instruction_decode_reg

Interface
REQ-001 Parameter NB_INSTR, default 32, instruction width.
REQ-002 Parameter NB_DATA, default 32, PC width.
REQ-003 Parameter NB_IMM, default 16, immediate field width.
REQ-004 Parameter NB_REG, default 5, register-address field width.
REQ-005 Port i_clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port i_rst, input, 1, reset; asynchronous, active-high.
REQ-007 Port i_instruction, input, NB_INSTR, fetched instruction from IF.
REQ-008 Port i_pc4, input, NB_DATA, PC+4 of the fetched instruction.
REQ-009 Port i_valid, input, 1, IF presents a real instruction.
REQ-010 Port i_stall, input, 1, hold the current contents (from hazard logic).
REQ-011 Port i_flush, input, 1, discard the current contents (taken branch/jump).
REQ-012 Port o_opcode, output, 6, bits [31:26] of the latched instruction.
REQ-013 Ports o_rs, o_rt, o_rd, outputs, NB_REG each, bits [25:21], [20:16], [15:11].
REQ-014 Ports o_shamt (5) and o_funct (6), outputs, bits [10:6] and [5:0].
REQ-015 Port o_immediate, output, NB_IMM, bits [15:0]; feeds the sign-extension stage.
REQ-016 Port o_immediate_flag, output, 1; 1 = sign-extend, 0 = zero-extend; feeds the sign-extension stage.
REQ-017 Port o_jump_addr, output, 26, bits [25:0].
REQ-018 Port o_pc4, output, NB_DATA, latched PC+4.
REQ-019 Port o_is_rtype, output, 1, latched opcode equals 6'h00.
REQ-020 Port o_valid, output, 1, outputs describe a real instruction.

Function
REQ-021 Register stage with one-cycle latency: instruction present at edge N appears on outputs after edge N.
REQ-022 All field outputs are registered or derived purely from registered state; no combinational path from i_instruction to any output.
REQ-023 Per-edge priority: i_rst > i_flush > i_stall > load.
REQ-024 Load: instruction register <= i_instruction, pc4 register <= i_pc4, valid register <= i_valid.
REQ-025 Stall (i_flush=0): every register holds its value, including o_valid.
REQ-026 Flush: instruction register <= 32'h0 (NOP), pc4 register <= 0, valid register <= 0; i_stall is ignored in that cycle.
REQ-027 Load with i_valid=0: instruction register <= 32'h0, so a bubble always decodes as NOP.
REQ-028 o_immediate_flag = 0 for opcode 6'h0C (ANDI), 6'h0D (ORI), 6'h0E (XORI), 6'h0F (LUI); 1 for every other opcode, including R-type and NOP.
REQ-029 Field extraction is pure bit slicing; no arithmetic is performed.
REQ-030 Simultaneous flush and stall: the flush wins and the stage becomes empty (REQ-026).
REQ-031 Consecutive stall cycles of any length hold the outputs stable; the first non-stall cycle loads the current inputs.

Reset
REQ-032 While i_rst=1, every output is immediately 0, except o_immediate_flag=1 and o_is_rtype=1 (decode of the NOP instruction 32'h0).
REQ-033 Reset asserted mid-operation clears the stage asynchronously, without waiting for a clock edge.
REQ-034 After i_rst is released, the first rising edge performs a normal load.

Verification
REQ-035 Reset then load 32'h2128FFFF (ADDI), i_valid=1, i_pc4=32'h4 -> next cycle: opcode=08, rs=9, rt=8, imm=FFFF, flag=1, o_pc4=4, valid=1.
REQ-036 Load 32'h352800FF (ORI) -> opcode=0D, rs=9, rt=8, imm=00FF, flag=0, is_rtype=0.
REQ-037 Load 32'h012A4020 (ADD) -> is_rtype=1, rs=9, rt=10, rd=8, shamt=0, funct=20, flag=1.
REQ-038 Load the ADDI, then i_stall=1 for 3 cycles while i_instruction changes -> outputs unchanged for all 3 cycles; the 4th edge with i_stall=0 loads the new instruction.
REQ-039 i_flush=1 and i_stall=1 together while holding a valid instruction -> next cycle: valid=0, all fields 0, flag=1.
REQ-040 Assert i_rst between clock edges while valid=1 -> outputs go to reset values before the next edge.
